// File: rtl/mpi_port_regs.sv
// mpi_port_regs: MPI bus-slave register block for the parallel port (177714)
// and the system register (177716).
//
// Ports:
//   CLKp, RSTp        clock (posedge) and async active-high reset
//   nADp              multiplexed address/data bus, active-low. Driven only while
//                     a selected read strobe is low.
//   nSYNCp, nDINp,    bus cycle frame, read strobe and write strobe (active-low)
//   nDOUTp
//   nWTBTp            low in the address phase = write; low in the data phase = byte
//   nSEL1p, nSEL2p    decoded selects for 177716 and 177714 (active-low)
//   PORT_INp, SYS_INp values returned on reads of 177714 / 177716
//   PORT_OUTp         parallel-port output latch
//   SYS_OUTp          system-register output latch (writable bits set by SYS_MASK)
//   PORT_WRp, SYS_WRp one-cycle pulses that follow each accepted write
//
// Control inputs and the inverted bus pass through matching synchroniser
// pipelines, so the bus data seen alongside a synchronised strobe is the data
// that was on the pins when that strobe changed.
module mpi_port_regs #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] PORT_RST    = 16'h0000,
    parameter logic [7:0]  SYS_MASK    = 8'hF0
) (
    input  logic        CLKp,
    input  logic        RSTp,
    inout  wire  [15:0] nADp,
    input  logic        nSYNCp,
    input  logic        nDINp,
    input  logic        nDOUTp,
    input  logic        nWTBTp,
    input  logic        nSEL1p,
    input  logic        nSEL2p,
    input  logic [15:0] PORT_INp,
    input  logic [15:0] SYS_INp,
    output logic [15:0] PORT_OUTp,
    output logic [7:0]  SYS_OUTp,
    output logic        PORT_WRp,
    output logic        SYS_WRp
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    // Control vector layout: {nSYNC, nDIN, nDOUT, nWTBT, nSEL1, nSEL2}
    logic [SYNC_STAGES-1:0][5:0]  r_ctl_pipe;
    logic [SYNC_STAGES-1:0][15:0] r_dat_pipe;

    always_ff @(posedge CLKp or posedge RSTp) begin
        if (RSTp) begin
            r_ctl_pipe <= '1;
            r_dat_pipe <= '0;
        end else begin
            r_ctl_pipe[0] <= {nSYNCp, nDINp, nDOUTp, nWTBTp, nSEL1p, nSEL2p};
            r_dat_pipe[0] <= ~nADp;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ctl_pipe[i] <= r_ctl_pipe[i-1];
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    logic        w_s_nsync, w_s_ndin, w_s_ndout, w_s_nwtbt, w_s_nsel1, w_s_nsel2;
    logic [15:0] w_s_d;

    assign {w_s_nsync, w_s_ndin, w_s_ndout, w_s_nwtbt, w_s_nsel1, w_s_nsel2} =
        r_ctl_pipe[SYNC_STAGES-1];
    assign w_s_d = r_dat_pipe[SYNC_STAGES-1];

    state_t r_state, w_next;
    logic   r_sync_q;                     // previous s_nSYNC, for falling-edge detect
    logic   r_sel_port, r_sel_sys, r_a0;  // captured in the address phase
    logic   w_capture, w_wr_port, w_wr_sys;

    // The write is applied on the ADDR->WRITE edge, the first cycle in which
    // s_nDOUT is seen low, so the synchronised data is still aligned with it.
    // Checking s_nSYNC first makes an abort beat a simultaneous write strobe.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_wr_port = 1'b0;
        w_wr_sys  = 1'b0;
        if (w_s_nsync) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_sync_q) begin
                        w_capture = 1'b1;
                        w_next    = (w_s_nsel1 && w_s_nsel2) ? ST_DONE : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!w_s_ndout) begin
                        w_next    = ST_WRITE;
                        w_wr_port = r_sel_port;
                        // odd-byte writes to the system register are ignored
                        w_wr_sys  = r_sel_sys && (w_s_nwtbt || !r_a0);
                    end else if (!w_s_ndin) begin
                        w_next = ST_READ;
                    end
                end
                ST_WRITE: w_next = ST_DONE;
                ST_READ:  if (w_s_ndin) w_next = ST_DONE;
                ST_DONE:  w_next = ST_DONE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKp or posedge RSTp) begin
        if (RSTp) begin
            r_state    <= ST_IDLE;
            r_sync_q   <= 1'b1;
            r_sel_port <= 1'b0;
            r_sel_sys  <= 1'b0;
            r_a0       <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sync_q <= w_s_nsync;
            if (w_capture) begin
                // nSEL2 wins when both selects are low
                r_sel_port <= !w_s_nsel2;
                r_sel_sys  <= w_s_nsel2 && !w_s_nsel1;
                r_a0       <= w_s_d[0];
            end
        end
    end

    logic r_port_pend, r_sys_pend;

    // Strobes lag the latch update by one edge via the pend flops.
    always_ff @(posedge CLKp or posedge RSTp) begin
        if (RSTp) begin
            PORT_OUTp   <= PORT_RST;
            SYS_OUTp    <= '0;
            r_port_pend <= 1'b0;
            r_sys_pend  <= 1'b0;
            PORT_WRp    <= 1'b0;
            SYS_WRp     <= 1'b0;
        end else begin
            r_port_pend <= w_wr_port;
            r_sys_pend  <= w_wr_sys;
            PORT_WRp    <= r_port_pend;
            SYS_WRp     <= r_sys_pend;
            if (w_wr_port) begin
                if (w_s_nwtbt)  PORT_OUTp        <= w_s_d;
                else if (r_a0)  PORT_OUTp[15:8]  <= w_s_d[15:8];
                else            PORT_OUTp[7:0]   <= w_s_d[7:0];
            end
            if (w_wr_sys)
                SYS_OUTp <= (SYS_OUTp & ~SYS_MASK) | (w_s_d[7:0] & SYS_MASK);
        end
    end

    // Read data is combinational on the raw pins to meet CPU sampling time.
    logic        w_rd_en;
    logic [15:0] w_rd_val;

    assign w_rd_en  = !RSTp && !nDINp && (!nSEL2p || !nSEL1p);
    assign w_rd_val = !nSEL2p ? PORT_INp : SYS_INp;
    assign nADp     = w_rd_en ? ~w_rd_val : 16'bz;

endmodule

// File: tb/tb_mpi_port_regs.sv
module tb_mpi_port_regs;

    localparam logic [7:0]  MASK  = 8'hF0;
    localparam logic [15:0] P_RST = 16'h0000;

    logic        CLKp = 1'b0;
    logic        RSTp;
    logic        nSYNC, nDIN, nDOUT, nWTBT, nSEL1, nSEL2;
    logic [15:0] PORT_IN, SYS_IN;
    logic [15:0] PORT_OUTp;
    logic [7:0]  SYS_OUTp;
    logic        PORT_WRp, SYS_WRp;
    logic        drv_en;
    logic [15:0] drv;
    wire  [15:0] nAD;

    assign nAD = drv_en ? drv : 16'bz;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (nAD[g]);
    end

    always #5 CLKp = ~CLKp;

    mpi_port_regs #(.SYNC_STAGES(2), .PORT_RST(P_RST), .SYS_MASK(MASK)) dut (
        .CLKp(CLKp), .RSTp(RSTp), .nADp(nAD),
        .nSYNCp(nSYNC), .nDINp(nDIN), .nDOUTp(nDOUT), .nWTBTp(nWTBT),
        .nSEL1p(nSEL1), .nSEL2p(nSEL2),
        .PORT_INp(PORT_IN), .SYS_INp(SYS_IN),
        .PORT_OUTp(PORT_OUTp), .SYS_OUTp(SYS_OUTp),
        .PORT_WRp(PORT_WRp), .SYS_WRp(SYS_WRp)
    );

    int n_tests = 0, n_fail = 0;
    int pwr_cnt = 0, swr_cnt = 0;
    bit long_pulse = 0;
    logic pwr_q = 0, swr_q = 0;
    logic [15:0] exp_port;
    logic [7:0]  exp_sys;

    // strobe monitor, sampled on the inactive edge
    always @(negedge CLKp) begin
        if (PORT_WRp) pwr_cnt++;
        if (SYS_WRp)  swr_cnt++;
        if ((PORT_WRp && pwr_q) || (SYS_WRp && swr_q)) long_pulse = 1;
        pwr_q = PORT_WRp;
        swr_q = SYS_WRp;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] addr_of(input int sel, input bit a0);
        return 16'hFFCC | ((sel == 2) ? 16'h0002 : 16'h0000) | {15'd0, a0};
    endfunction

    task automatic end_frame();
        nSYNC = 1; drv_en = 0; nSEL1 = 1; nSEL2 = 1; nWTBT = 1;
        repeat (5) @(negedge CLKp);
    endtask

    // sel: 0 none, 1 port (177714), 2 system (177716)
    task automatic do_write(input int sel, input bit a0, input bit bw, input logic [15:0] d,
                            input int dlen, input bit ab);
        @(negedge CLKp);
        drv_en = 1; drv = ~addr_of(sel, a0); nWTBT = 0;
        nSEL1 = (sel != 2); nSEL2 = (sel != 1);
        @(negedge CLKp); nSYNC = 0;
        repeat (3) @(negedge CLKp);
        drv = ~d; nWTBT = !bw; nDOUT = 0;
        if (ab) nSYNC = 1;
        @(negedge CLKp);
        drv = d;   // bus moves on; the write must keep the earlier data
        repeat (dlen - 1) @(negedge CLKp);
        nDOUT = 1;
        repeat (2) @(negedge CLKp);
        end_frame();
    endtask

    task automatic do_read(input int sel, input bit both, input logic [15:0] exp_bus,
                           input string tag);
        @(negedge CLKp);
        drv_en = 1; drv = ~addr_of(sel, 0); nWTBT = 1;
        nSEL1 = !(sel == 2 || both); nSEL2 = !(sel == 1 || both);
        @(negedge CLKp); nSYNC = 0;
        repeat (2) @(negedge CLKp);
        drv_en = 0;
        @(negedge CLKp);
        chk({tag, ".pre"}, nAD, 16'hFFFF);
        nDIN = 0; #1;
        chk({tag, ".during"}, nAD, exp_bus);
        repeat (2) @(negedge CLKp);
        chk({tag, ".during2"}, nAD, exp_bus);
        nDIN = 1; #1;
        chk({tag, ".post"}, nAD, 16'hFFFF);
        @(negedge CLKp);
        end_frame();
    endtask

    task automatic post(input string tag, input int pw0, input int sw0,
                        input int epw, input int esw);
        chk({tag, ".port"}, PORT_OUTp, exp_port);
        chk({tag, ".sys"}, SYS_OUTp, exp_sys);
        chk({tag, ".pwr"}, pwr_cnt - pw0, epw);
        chk({tag, ".swr"}, swr_cnt - sw0, esw);
        chk({tag, ".len"}, long_pulse, 0);
    endtask

    typedef struct {
        int          sel;
        bit          a0;
        bit          bw;
        logic [15:0] d;
        logic [15:0] ep;
        logic [7:0]  es;
        int          epw;
        int          esw;
    } vec_t;

    vec_t vt[9];

    initial begin
        int pw0, sw0;
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int pw0, sw0, sel, epw, esw, dlen;
        bit a0, bw, ab;
        logic [15:0] d, eb;

        vt[0] = '{1, 0, 0, 16'h000F, 16'h000F, 8'h00, 1, 0};
        vt[1] = '{1, 0, 0, 16'hABCD, 16'hABCD, 8'h00, 1, 0};
        vt[2] = '{1, 0, 1, 16'h0055, 16'hAB55, 8'h00, 1, 0};
        vt[3] = '{1, 1, 1, 16'h1200, 16'h1255, 8'h00, 1, 0};
        vt[4] = '{2, 0, 0, 16'h00FF, 16'h1255, 8'hF0, 0, 1};
        vt[5] = '{2, 1, 1, 16'h0000, 16'h1255, 8'hF0, 0, 0};
        vt[6] = '{2, 0, 1, 16'h0030, 16'h1255, 8'h30, 0, 1};
        vt[7] = '{0, 0, 0, 16'h0000, 16'h1255, 8'h30, 0, 0};
        vt[8] = '{2, 0, 0, 16'h000A, 16'h1255, 8'h00, 0, 1};

        RSTp = 1; nSYNC = 1; nDIN = 0; nDOUT = 1; nWTBT = 1; nSEL1 = 1; nSEL2 = 0;
        drv_en = 0; drv = 0; PORT_IN = 16'h1234; SYS_IN = 16'h0000;
        repeat (3) @(negedge CLKp);
        chk("rst.port", PORT_OUTp, P_RST);
        chk("rst.sys", SYS_OUTp, 0);
        chk("rst.wr", {PORT_WRp, SYS_WRp}, 0);
        chk("rst.bus", nAD, 16'hFFFF);
        nDIN = 1; nSEL2 = 1;
        RSTp = 0;
        repeat (3) @(negedge CLKp);
        exp_port = P_RST; exp_sys = 0;

        for (int i = 0; i < 9; i++) begin
            pw0 = pwr_cnt; sw0 = swr_cnt;
            do_write(vt[i].sel, vt[i].a0, vt[i].bw, vt[i].d, 2, 0);
            exp_port = vt[i].ep; exp_sys = vt[i].es;
            post($sformatf("vec%0d", i), pw0, sw0, vt[i].epw, vt[i].esw);
        end

        // latency: port update on edge 3 after nDOUT falls, strobe on edge 4 only
        @(negedge CLKp);
        drv_en = 1; drv = ~16'hFFCC; nWTBT = 0; nSEL2 = 0;
        @(negedge CLKp); nSYNC = 0;
        repeat (3) @(negedge CLKp);
        drv = ~16'hC3C3; nWTBT = 1; nDOUT = 0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge CLKp); #1;
            chk($sformatf("lat.port.e%0d", e), PORT_OUTp, (e >= 3) ? 16'hC3C3 : exp_port);
            chk($sformatf("lat.wr.e%0d", e), PORT_WRp, (e == 4) ? 1 : 0);
            if (e == 2) nDOUT = 1;
        end
        end_frame();
        exp_port = 16'hC3C3;

        // reads
        pw0 = pwr_cnt; sw0 = swr_cnt;
        PORT_IN = 16'h1234; SYS_IN = 16'hBEEF;
        do_read(1, 0, ~16'h1234, "rd.port");
        do_read(2, 0, ~16'hBEEF, "rd.sys");
        do_read(0, 0, 16'hFFFF, "rd.none");
        do_read(0, 1, ~16'h1234, "rd.both");
        post("rd", pw0, sw0, 0, 0);

        // aborted frame and long nDOUT
        pw0 = pwr_cnt; sw0 = swr_cnt;
        do_write(1, 0, 0, 16'h0F0F, 2, 1);
        post("abort", pw0, sw0, 0, 0);
        pw0 = pwr_cnt; sw0 = swr_cnt;
        do_write(1, 0, 0, 16'h7777, 8, 0);
        exp_port = 16'h7777;
        post("longdout", pw0, sw0, 1, 0);

        // reset while nDOUT is low, then a clean write
        pw0 = pwr_cnt; sw0 = swr_cnt;
        @(negedge CLKp);
        drv_en = 1; drv = ~16'hFFCC; nWTBT = 0; nSEL2 = 0;
        @(negedge CLKp); nSYNC = 0;
        repeat (3) @(negedge CLKp);
        drv = ~16'h5A5A; nWTBT = 1; nDOUT = 0;
        @(posedge CLKp); #1; RSTp = 1;
        @(negedge CLKp); nDOUT = 1;
        @(negedge CLKp); RSTp = 0;
        repeat (2) @(negedge CLKp);
        end_frame();
        exp_port = P_RST; exp_sys = 0;
        post("midrst", pw0, sw0, 0, 0);
        pw0 = pwr_cnt; sw0 = swr_cnt;
        do_write(1, 0, 0, 16'h1357, 2, 0);
        exp_port = 16'h1357;
        post("afterrst", pw0, sw0, 1, 0);

        // randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            pw0 = pwr_cnt; sw0 = swr_cnt;
            sel = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
                PORT_IN = 16'($urandom); SYS_IN = 16'($urandom);
                eb = (sel == 1) ? ~PORT_IN : (sel == 2) ? ~SYS_IN : 16'hFFFF;
                do_read(sel, 0, eb, $sformatf("rnd%0d.rd", k));
                post($sformatf("rnd%0d", k), pw0, sw0, 0, 0);
            end else begin
                a0 = 1'($urandom); bw = 1'($urandom); d = 16'($urandom);
                dlen = $urandom_range(1, 5);
                ab = ($urandom_range(0, 7) == 0);
                epw = 0; esw = 0;
                if (!ab && sel == 1) begin
                    epw = 1;
                    if (!bw)     exp_port = d;
                    else if (a0) exp_port = {d[15:8], exp_port[7:0]};
                    else         exp_port = {exp_port[15:8], d[7:0]};
                end
                if (!ab && sel == 2 && (!bw || !a0)) begin
                    esw = 1;
                    exp_sys = (exp_sys & ~MASK) | (d[7:0] & MASK);
                end
                do_write(sel, a0, bw, d, dlen, ab);
                post($sformatf("rnd%0d", k), pw0, sw0, epw, esw);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
